// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the branch predictor: bus widths, update record layout and
// 2-bit direction counter encoding with saturating step helpers.
package branch_predict_unit_pkg;

    localparam int unsigned BPU_TO_PS_BUS_WD = 33;

    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrWt  = 2'b10,
        CtrSt  = 2'b11
    } ctr_e;

    // Registered update record; key_word is (branch PC + 4) >> 2.
    typedef struct packed {
        logic        taken;
        logic [29:0] key_word;
        logic [31:0] target;
    } upd_bus_t;

    function automatic ctr_e sat_inc(ctr_e c);
        ctr_e r;
        unique case (c)
            CtrSnt:  r = CtrWnt;
            CtrWnt:  r = CtrWt;
            CtrWt:   r = CtrSt;
            default: r = CtrSt;
        endcase
        return r;
    endfunction

    function automatic ctr_e sat_dec(ctr_e c);
        ctr_e r;
        unique case (c)
            CtrSt:   r = CtrWt;
            CtrWt:   r = CtrWnt;
            CtrWnt:  r = CtrSnt;
            default: r = CtrSnt;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bpu_table.sv
// Direct-mapped predictor storage: two async read ports (lookup and update
// read-modify-write), one sync write port and a single-cycle valid clear.
module bpu_table
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TAG_W = 32 - IDX_W - 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear_i,

    input  logic [IDX_W-1:0]  lk_idx_i,
    output logic              lk_valid_o,
    output logic [TAG_W-1:0]  lk_tag_o,
    output logic [31:0]       lk_target_o,
    output ctr_e              lk_ctr_o,

    input  logic [IDX_W-1:0]  up_idx_i,
    output logic              up_valid_o,
    output logic [TAG_W-1:0]  up_tag_o,
    output logic [31:0]       up_target_o,
    output ctr_e              up_ctr_o,

    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [31:0]       wr_target_i,
    input  ctr_e              wr_ctr_i
);

    localparam int unsigned Entries = 2 ** IDX_W;

    logic [Entries-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [Entries];
    logic [31:0]        target_q [Entries];
    ctr_e               ctr_q    [Entries];

    always_comb begin
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = '0;
        end else if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (resetn && wr_en_i && !clear_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
            ctr_q[wr_idx_i]    <= wr_ctr_i;
        end
    end

    always_comb begin
        lk_valid_o  = valid_q[lk_idx_i];
        lk_tag_o    = tag_q[lk_idx_i];
        lk_target_o = target_q[lk_idx_i];
        lk_ctr_o    = ctr_q[lk_idx_i];
        up_valid_o  = valid_q[up_idx_i];
        up_tag_o    = tag_q[up_idx_i];
        up_target_o = target_q[up_idx_i];
        up_ctr_o    = ctr_q[up_idx_i];
    end

endmodule

// File: rtl/branch_predict_unit.sv
// BTB keyed by delay-slot PC: combinational lookup toward pre-IF, a one-cycle
// registered training stage from execute, and hit / mispredict counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [31:0]                 lookup_pc,
    output logic [BPU_TO_PS_BUS_WD-1:0] BPU_to_ps_bus,
    input  logic                        upd_valid,
    input  logic                        upd_is_branch,
    input  logic                        upd_taken,
    input  logic [31:0]                 upd_pc,
    input  logic [31:0]                 upd_target,
    input  logic                        upd_mispredict,
    input  logic                        bpu_clear,
    output logic [31:0]                 hit_count,
    output logic [31:0]                 mispred_count
);

    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic             lk_valid;
    logic [TAG_W-1:0] lk_tag;
    logic [31:0]      lk_target;
    ctr_e             lk_ctr;

    logic             up_valid;
    logic [TAG_W-1:0] up_tag;
    logic [31:0]      up_target;
    ctr_e             up_ctr;

    logic             wr_en;
    logic [TAG_W-1:0] wr_tag;
    logic [31:0]      wr_target;
    ctr_e             wr_ctr;

    logic             u1_valid_q, u1_valid_d;
    upd_bus_t         u1_q, u1_d;
    logic [31:0]      hit_count_q, hit_count_d;
    logic [31:0]      mispred_count_q, mispred_count_d;

    logic             capture;
    logic             bpu_valid;
    logic [31:0]      bpu_target;
    logic [IDX_W-1:0] u1_idx;
    logic [TAG_W-1:0] u1_tag;
    logic             up_hit;
    logic [1:0]       unused_pc_lsb;

    // Bits [1:0] of the branch PC do not affect the word-aligned key.
    assign unused_pc_lsb = upd_pc[1:0];

    assign capture = upd_valid & upd_is_branch;
    assign u1_idx  = u1_q.key_word[IDX_W-1:0];
    assign u1_tag  = u1_q.key_word[29:IDX_W];
    assign up_hit  = up_valid & (up_tag == u1_tag);

    bpu_table #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_table (
        .clk         (clk),
        .resetn      (resetn),
        .clear_i     (bpu_clear),
        .lk_idx_i    (lookup_pc[IDX_W+1:2]),
        .lk_valid_o  (lk_valid),
        .lk_tag_o    (lk_tag),
        .lk_target_o (lk_target),
        .lk_ctr_o    (lk_ctr),
        .up_idx_i    (u1_idx),
        .up_valid_o  (up_valid),
        .up_tag_o    (up_tag),
        .up_target_o (up_target),
        .up_ctr_o    (up_ctr),
        .wr_en_i     (wr_en),
        .wr_idx_i    (u1_idx),
        .wr_tag_i    (wr_tag),
        .wr_target_i (wr_target),
        .wr_ctr_i    (wr_ctr)
    );

    // Lookup is qualified by resetn so the bus reads zero while reset is held.
    always_comb begin
        bpu_valid = resetn & lk_valid & (lk_tag == lookup_pc[31:IDX_W+2])
                  & lk_ctr[1] & (lookup_pc[1:0] == 2'b00);
        bpu_target    = bpu_valid ? lk_target : 32'h0;
        BPU_to_ps_bus = {bpu_target, bpu_valid};
    end

    // Training rules applied to the registered update; a clear drops it.
    always_comb begin
        wr_en     = 1'b0;
        wr_tag    = u1_tag;
        wr_target = u1_q.target;
        wr_ctr    = CtrWt;
        if (u1_valid_q && !bpu_clear) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (u1_q.taken) begin
                    wr_ctr = sat_inc(up_ctr);
                end else begin
                    wr_ctr    = sat_dec(up_ctr);
                    wr_target = up_target;
                end
            end else if (u1_q.taken) begin
                wr_en = 1'b1;
            end
        end
    end

    always_comb begin
        u1_valid_d      = capture;
        u1_d            = u1_q;
        hit_count_d     = hit_count_q + {31'd0, bpu_valid};
        mispred_count_d = mispred_count_q;
        if (capture) begin
            u1_d.taken    = upd_taken;
            u1_d.key_word = upd_pc[31:2] + 30'd1;
            u1_d.target   = upd_target;
            if (upd_mispredict) begin
                mispred_count_d = mispred_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            u1_valid_q      <= 1'b0;
            hit_count_q     <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            u1_valid_q      <= u1_valid_d;
            hit_count_q     <= hit_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    always_ff @(posedge clk) begin
        u1_q <= u1_d;
    end

    assign hit_count     = hit_count_q;
    assign mispred_count = mispred_count_q;

endmodule
